// File: rtl/im_prefetch_buf_pkg.sv
// Shared processor package for the instruction prefetch buffer.
// Holds the default bus widths, the default queue depth and the
// fetch-control state encoding used by the interface and the RTL.
package im_prefetch_buf_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/im_prefetch_buf_if.sv
// Bundle of the control, instruction-memory and IF-stage signals of the
// prefetch buffer.
//   slave  : the prefetch buffer itself
//   master : whatever drives control/memory response and consumes inst_*
//
// Handshake: inst_valid_o and inst_ready_i follow valid/ready semantics --
// the head entry transfers on every rising clk edge where both are high;
// inst_valid_o never depends on inst_ready_i, and inst_o/inst_pc_o hold
// steady while inst_valid_o is high and the entry has not been taken (a
// redirect may withdraw the entry).
// The memory side is a fixed-latency read: im_r_data_i carries the word for
// im_addr_o exactly one cycle after im_rd_o was high.
// state exposes the fetch-control FSM for observation.
interface im_prefetch_buf_if
  import im_prefetch_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  start;
  logic                  stop;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_addr_i;
  logic [ADDR_WIDTH-1:0] im_addr_o;
  logic                  im_rd_o;
  logic [DATA_WIDTH-1:0] im_r_data_i;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] inst_pc_o;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [CW-1:0]         count_o;
  state_t                state;

  modport slave (
    input  start, stop, redirect_i, redirect_addr_i, im_r_data_i, inst_ready_i,
    output im_addr_o, im_rd_o, inst_o, inst_pc_o, inst_valid_o, count_o, state
  );

  modport master (
    output start, stop, redirect_i, redirect_addr_i, im_r_data_i, inst_ready_i,
    input  im_addr_o, im_rd_o, inst_o, inst_pc_o, inst_valid_o, count_o, state
  );

endinterface

// File: rtl/im_prefetch_buf_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with a single-cycle flush.
// Ports: clk, rst (sync, active-high), flush (empties the queue, wins over
// push/pop), push/push_data, pop, head (registered storage at the read
// pointer), count (entries held, 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full queue is only legal when the head leaves that cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/im_prefetch_buf.sv
// im_prefetch_buf: instruction prefetch queue between a one-cycle-latency
// instruction memory and the IF stage.
// Ports: clk, rst (sync, active-high), bus (im_prefetch_buf_if.slave):
//   start/stop/redirect_i/redirect_addr_i  fetch control
//   im_addr_o/im_rd_o/im_r_data_i          instruction memory
//   inst_o/inst_pc_o/inst_valid_o/inst_ready_i  head of queue to IF
//   count_o                                 entries held
//   state                                   fetch FSM state
// The FSM walks IDLE -> FETCH -> HALT; HALT is left only through rst.
// Reads are issued only while queued + in-flight entries leave a free slot,
// so every returning word always has room.
module im_prefetch_buf
  import im_prefetch_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst,
  im_prefetch_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [CW-1:0]         count;
  logic [OW-1:0]         occupancy;
  logic                  issue;
  logic                  redirect_live;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  // Redirects only mean something while fetching.
  assign redirect_live = bus.redirect_i && (state == FETCH);
  assign occupancy     = OW'(count) + OW'(inflight);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = FETCH;
      end
      FETCH: begin
        // A redirect keeps the fetcher running even if stop is also high.
        if (bus.stop && !bus.redirect_i) state_next = HALT;
        issue = !bus.stop && !bus.redirect_i && (occupancy < OW'(DEPTH));
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (state == IDLE && bus.start) fetch_pc <= '0;
      else if (redirect_live)         fetch_pc <= bus.redirect_addr_i;
      else if (issue)                 fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
      // issue is low on a redirect, so this also drops the pending response.
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  assign push = inflight && !redirect_live;
  assign pop  = (count != '0) && bus.inst_ready_i && !redirect_live;

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_live),
    .push      (push),
    .push_data ({inflight_pc, bus.im_r_data_i}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.im_addr_o    = fetch_pc;
  assign bus.im_rd_o      = issue;
  assign bus.inst_pc_o    = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.inst_o       = head[DATA_WIDTH-1:0];
  assign bus.inst_valid_o = (count != '0);
  assign bus.count_o      = count;
  assign bus.state        = state;

endmodule

// File: tb/tb_im_prefetch_buf.sv
// Bench for im_prefetch_buf: directed scenarios, a queue-based reference of
// the prefetcher checked every cycle, and literal expectations per scenario.
module tb_im_prefetch_buf;
  import im_prefetch_buf_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic check_en;

  im_prefetch_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  im_prefetch_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: IM[n] = n + 0x100.
  function automatic logic [DW-1:0] im_word(input logic [AW-1:0] a);
    return 16'h0100 + {8'h00, a};
  endfunction

  // One-cycle-latency memory.
  always @(posedge clk) bus.im_r_data_i <= im_word(bus.im_addr_o);

  // ---------------- reference model ----------------
  state_t          m_state;
  logic [AW-1:0]   m_pc;
  logic            m_pend;
  logic [AW-1:0]   m_pend_pc;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] del_q[$];

  function automatic logic exp_rd();
    return (m_state == FETCH) && !bus.stop && !bus.redirect_i &&
           (exp_q.size() + (m_pend ? 1 : 0) < DEPTH);
  endfunction

  always @(posedge clk) begin
    logic rd;
    logic redir;
    rd    = exp_rd();
    redir = (m_state == FETCH) && bus.redirect_i;
    if (rst) begin
      m_state   = IDLE;
      m_pc      = '0;
      m_pend    = 1'b0;
      m_pend_pc = '0;
      exp_q.delete();
    end else if (redir) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_pc   = bus.redirect_addr_i;
    end else begin
      if (exp_q.size() != 0 && bus.inst_ready_i) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back({m_pend_pc, im_word(m_pend_pc)});
      m_pend = rd;
      if (rd) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 8'd1;
      end
      if (m_state == IDLE && bus.start) begin
        m_state = FETCH;
        m_pc    = '0;
      end else if (m_state == FETCH && bus.stop) begin
        m_state = HALT;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("im_rd_o",      32'(bus.im_rd_o),      32'(exp_rd()));
      cmp("im_addr_o",    32'(bus.im_addr_o),    32'(m_pc));
      cmp("inst_valid_o", 32'(bus.inst_valid_o), 32'(exp_q.size() != 0));
      cmp("count_o",      32'(bus.count_o),      32'(exp_q.size()));
      cmp("state",        32'(bus.state),        32'(m_state));
      if (exp_q.size() != 0) begin
        cmp("inst_pc_o", 32'(bus.inst_pc_o), 32'(exp_q[0][AW+DW-1:DW]));
        cmp("inst_o",    32'(bus.inst_o),    32'(exp_q[0][DW-1:0]));
      end
      if (!rst && bus.inst_valid_o && bus.inst_ready_i &&
          !(m_state == FETCH && bus.redirect_i))
        del_q.push_back({bus.inst_pc_o, bus.inst_o});
    end
  end

  // Delivered instructions must be n consecutive PCs from first_pc (mod 256)
  // each carrying IM[pc].
  task automatic check_del(input string name, input int first_pc, input int n);
    logic [AW-1:0] pc;
    cmp({name, "_count"}, 32'(del_q.size()), 32'(n));
    for (int i = 0; i < n && i < del_q.size(); i++) begin
      pc = AW'(first_pc + i);
      cmp({name, "_pc"},   32'(del_q[i][AW+DW-1:DW]), 32'(pc));
      cmp({name, "_data"}, 32'(del_q[i][DW-1:0]),     32'(16'h0100 + {8'h00, pc}));
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    check_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_addr_i = '0;
    bus.inst_ready_i = 1'b0;

    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cmp("rst_im_rd",   32'(bus.im_rd_o),      32'd0);
    cmp("rst_im_addr", 32'(bus.im_addr_o),    32'd0);
    cmp("rst_valid",   32'(bus.inst_valid_o), 32'd0);
    cmp("rst_inst",    32'(bus.inst_o),       32'd0);
    cmp("rst_pc",      32'(bus.inst_pc_o),    32'd0);
    cmp("rst_count",   32'(bus.count_o),      32'd0);

    // Streaming from address 0.
    bus.inst_ready_i = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cmp("a_addr0", 32'(bus.im_addr_o),    32'h00);
    cmp("a_rd0",   32'(bus.im_rd_o),      32'd1);
    cmp("a_v0",    32'(bus.inst_valid_o), 32'd0);
    tick();
    cmp("a_addr1", 32'(bus.im_addr_o),    32'h01);
    cmp("a_v1",    32'(bus.inst_valid_o), 32'd0);
    tick();
    cmp("a_v2",    32'(bus.inst_valid_o), 32'd1);
    cmp("a_inst",  32'(bus.inst_o),       32'h100);
    cmp("a_pc",    32'(bus.inst_pc_o),    32'h00);
    del_q.delete();
    repeat (6) tick();
    check_del("stream", 0, 6);

    // Back-pressure: queue fills to 4, fetch stalls, then drains in order.
    bus.inst_ready_i = 1'b0;
    repeat (10) tick();
    cmp("b_count", 32'(bus.count_o),   32'd4);
    cmp("b_rd",    32'(bus.im_rd_o),   32'd0);
    cmp("b_addr",  32'(bus.im_addr_o), 32'h0A);
    cmp("b_head",  32'(bus.inst_pc_o), 32'h06);
    del_q.delete();
    bus.inst_ready_i = 1'b1;
    repeat (4) tick();
    check_del("drain", 6, 4);
    cmp("b_resume", 32'(bus.inst_pc_o), 32'h0A);

    // Redirect with 3 queued and 1 in flight.
    bus.inst_ready_i = 1'b0;
    tick();
    cmp("c_count3", 32'(bus.count_o), 32'd3);
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 8'h40;
    #1;
    cmp("c_rd_redir", 32'(bus.im_rd_o), 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    #1;
    cmp("c_count0", 32'(bus.count_o),      32'd0);
    cmp("c_valid0", 32'(bus.inst_valid_o), 32'd0);
    cmp("c_addr",   32'(bus.im_addr_o),    32'h40);
    cmp("c_rd",     32'(bus.im_rd_o),      32'd1);
    tick();
    tick();
    cmp("c_valid", 32'(bus.inst_valid_o), 32'd1);
    cmp("c_pc",    32'(bus.inst_pc_o),    32'h40);
    cmp("c_inst",  32'(bus.inst_o),       32'h140);

    // Address wrap 0xFF -> 0x00.
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 8'hFC;
    tick();
    bus.redirect_i = 1'b0;
    del_q.delete();
    repeat (8) tick();
    check_del("wrap", 8'hFC, 6);
    cmp("d_addr", 32'(bus.im_addr_o), 32'h04);

    // Stop with 2 queued and 1 in flight.
    bus.inst_ready_i = 1'b0;
    tick();
    cmp("e_count2", 32'(bus.count_o), 32'd2);
    bus.stop = 1'b1;
    #1;
    cmp("e_rd_stop", 32'(bus.im_rd_o), 32'd0);
    tick();
    bus.stop = 1'b0;
    cmp("e_count3", 32'(bus.count_o), 32'd3);
    cmp("e_halt",   32'(bus.state),   32'(HALT));
    del_q.delete();
    bus.inst_ready_i = 1'b1;
    bus.start = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 8'h10;
    tick();
    bus.start = 1'b0;
    bus.redirect_i = 1'b0;
    repeat (4) tick();
    check_del("stop_drain", 2, 3);
    cmp("e_valid", 32'(bus.inst_valid_o), 32'd0);
    cmp("e_rd",    32'(bus.im_rd_o),      32'd0);
    cmp("e_state", 32'(bus.state),        32'(HALT));

    // Reset mid-operation with a read in flight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.inst_ready_i = 1'b0;
    repeat (4) tick();
    cmp("f_count3", 32'(bus.count_o), 32'd3);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 8'h33;
    tick();
    cmp("f_rd",    32'(bus.im_rd_o),      32'd0);
    cmp("f_addr",  32'(bus.im_addr_o),    32'd0);
    cmp("f_valid", 32'(bus.inst_valid_o), 32'd0);
    cmp("f_inst",  32'(bus.inst_o),       32'd0);
    cmp("f_pc",    32'(bus.inst_pc_o),    32'd0);
    cmp("f_count", 32'(bus.count_o),      32'd0);
    cmp("f_state", 32'(bus.state),        32'(IDLE));
    rst = 1'b0;
    bus.start = 1'b0;
    bus.redirect_i = 1'b0;
    tick();
    cmp("f_stale_count", 32'(bus.count_o),      32'd0);
    cmp("f_stale_valid", 32'(bus.inst_valid_o), 32'd0);
    cmp("f_idle",        32'(bus.state),        32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
